// File: rtl/tc_ram_arbiter_pkg.sv
// Shared definitions for the TotalCoeff RAM arbiter: owner tags, FSM
// encoding and the TC address field layout used by nC decode and deblock.
package tc_ram_arbiter_pkg;

   localparam int TC_MBH_W      = 7;
   localparam int TC_MBV_W      = 1;
   localparam int TC_BLK_W      = 5;
   localparam int TC_ADDR_W     = TC_MBH_W + TC_MBV_W + TC_BLK_W;
   localparam int TC_DATA_W     = 5;
   localparam int TC_STARVE_MAX = 4;

   // Who owns the read data returning from the RAM next cycle
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_NC   = 2'd1,
      OWN_DB   = 2'd2
   } owner_e;

   localparam logic [0:0] ST_SERVE = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   // Pack macroblock column, row parity and block index into a TC address
   function automatic logic [TC_ADDR_W-1:0] tc_addr(
      input logic [TC_MBH_W-1:0] mb_h,
      input logic [TC_MBV_W-1:0] mb_v,
      input logic [TC_BLK_W-1:0] blk
   );
      return {mb_h, mb_v, blk};
   endfunction

endpackage

// File: rtl/tc_ram_arbiter_if.sv
// Requester and RAM-macro bus of the TotalCoeff RAM arbiter.
// slave = arbiter view, master = requester/RAM side view.
interface tc_ram_arbiter_if
   import tc_ram_arbiter_pkg::*;
#(
   parameter int ADDR_W = TC_ADDR_W,
   parameter int DATA_W = TC_DATA_W
);

   logic              init_start;
   logic              init_done;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_gnt;
   logic              nc_rd_req;
   logic [ADDR_W-1:0] nc_rd_addr;
   logic              nc_rd_gnt;
   logic              nc_rd_valid;
   logic [DATA_W-1:0] nc_rd_data;
   logic              db_rd_req;
   logic [ADDR_W-1:0] db_rd_addr;
   logic              db_rd_gnt;
   logic              db_rd_valid;
   logic [DATA_W-1:0] db_rd_data;
   logic              ram_cs;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  init_start, wr_req, wr_addr, wr_data,
      input  nc_rd_req, nc_rd_addr, db_rd_req, db_rd_addr, ram_rdata,
      output init_done, wr_gnt, nc_rd_gnt, nc_rd_valid, nc_rd_data,
      output db_rd_gnt, db_rd_valid, db_rd_data,
      output ram_cs, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output init_start, wr_req, wr_addr, wr_data,
      output nc_rd_req, nc_rd_addr, db_rd_req, db_rd_addr, ram_rdata,
      input  init_done, wr_gnt, nc_rd_gnt, nc_rd_valid, nc_rd_data,
      input  db_rd_gnt, db_rd_valid, db_rd_data,
      input  ram_cs, ram_we, ram_addr, ram_wdata
   );

endinterface

// File: rtl/tc_arb_prio.sv
// Combinational fixed-priority grant for the TC RAM: write always wins,
// a starved deblock read jumps ahead of the nC read, otherwise nC beats deblock.
module tc_arb_prio (
   input  logic en,
   input  logic wr_req,
   input  logic nc_req,
   input  logic db_req,
   input  logic db_starved,
   output logic wr_gnt,
   output logic nc_gnt,
   output logic db_gnt
);

   // One-hot grant selection, all grants low while the RAM is not serving
   always_comb begin
      wr_gnt = 1'b0;
      nc_gnt = 1'b0;
      db_gnt = 1'b0;
      if (!en) begin
         wr_gnt = 1'b0;
      end else if (wr_req) begin
         wr_gnt = 1'b1;
      end else if (db_req && db_starved) begin
         db_gnt = 1'b1;
      end else if (nc_req) begin
         nc_gnt = 1'b1;
      end else if (db_req) begin
         db_gnt = 1'b1;
      end else begin
         wr_gnt = 1'b0;
      end
   end

endmodule

// File: rtl/tc_ram_arbiter.sv
// TotalCoeff RAM owner: arbitrates write-back, nC and deblock reads onto the
// single RAM port, sequences the picture-start clear and returns read data.
module tc_ram_arbiter
   import tc_ram_arbiter_pkg::*;
#(
   parameter int ADDR_W     = TC_ADDR_W,
   parameter int DATA_W     = TC_DATA_W,
   parameter int STARVE_MAX = TC_STARVE_MAX
) (
   input logic             clk,
   input logic             reset,
   tc_ram_arbiter_if.slave bus
);

   localparam int              SW         = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              done_q, done_d;
   logic [SW-1:0]     starve_q, starve_d;
   owner_e            owner_q, owner_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] nc_data_q, nc_data_d;
   logic [DATA_W-1:0] db_data_q, db_data_d;

   logic serve_s, wr_gnt_s, nc_gnt_s, db_gnt_s, cs_s, we_s;

   assign serve_s = (state_q == ST_SERVE);

   tc_arb_prio u_prio (
      .en         (serve_s),
      .wr_req     (bus.wr_req),
      .nc_req     (bus.nc_rd_req),
      .db_req     (bus.db_rd_req),
      .db_starved (starve_q == STARVE_LIM),
      .wr_gnt     (wr_gnt_s),
      .nc_gnt     (nc_gnt_s),
      .db_gnt     (db_gnt_s)
   );

   // Clear sequencing: init_start (re)starts the sweep, last address returns to SERVE
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         ST_SERVE: begin
            if (bus.init_start) begin
               state_d = ST_CLEAR;
               cnt_d   = {ADDR_W{1'b0}};
            end else begin
               state_d = ST_SERVE;
            end
         end
         ST_CLEAR: begin
            if (bus.init_start) begin
               cnt_d = {ADDR_W{1'b0}};
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_SERVE;
               cnt_d   = {ADDR_W{1'b0}};
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_d = ST_SERVE;
            cnt_d   = {ADDR_W{1'b0}};
         end
      endcase
   end

   // RAM port mux: clear sweep, else the winner, else idle holding address/data
   always_comb begin
      cs_s    = 1'b0;
      we_s    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (!serve_s) begin
         cs_s    = 1'b1;
         we_s    = 1'b1;
         addr_d  = cnt_q;
         wdata_d = {DATA_W{1'b0}};
      end else if (wr_gnt_s) begin
         cs_s    = 1'b1;
         we_s    = 1'b1;
         addr_d  = bus.wr_addr;
         wdata_d = bus.wr_data;
      end else if (nc_gnt_s) begin
         cs_s   = 1'b1;
         addr_d = bus.nc_rd_addr;
      end else if (db_gnt_s) begin
         cs_s   = 1'b1;
         addr_d = bus.db_rd_addr;
      end else begin
         cs_s = 1'b0;
      end
   end

   // Deblock starvation count: grows while db waits, saturates, clears on grant or drop
   always_comb begin
      starve_d = {SW{1'b0}};
      if (bus.db_rd_req && !db_gnt_s) begin
         if (starve_q == STARVE_LIM) begin
            starve_d = starve_q;
         end else begin
            starve_d = starve_q + {{(SW-1){1'b0}}, 1'b1};
         end
      end else begin
         starve_d = {SW{1'b0}};
      end
   end

   // Read return: tag the owner at grant, steer RAM data to it next cycle
   always_comb begin
      owner_d   = OWN_NONE;
      nc_data_d = nc_data_q;
      db_data_d = db_data_q;
      if (nc_gnt_s) begin
         owner_d = OWN_NC;
      end else if (db_gnt_s) begin
         owner_d = OWN_DB;
      end else begin
         owner_d = OWN_NONE;
      end
      if (owner_q == OWN_NC) begin
         nc_data_d = bus.ram_rdata;
      end else if (owner_q == OWN_DB) begin
         db_data_d = bus.ram_rdata;
      end else begin
         nc_data_d = nc_data_q;
      end
   end

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_SERVE;
         cnt_q     <= {ADDR_W{1'b0}};
         done_q    <= 1'b0;
         starve_q  <= {SW{1'b0}};
         owner_q   <= OWN_NONE;
         addr_q    <= {ADDR_W{1'b0}};
         wdata_q   <= {DATA_W{1'b0}};
         nc_data_q <= {DATA_W{1'b0}};
         db_data_q <= {DATA_W{1'b0}};
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         starve_q  <= starve_d;
         owner_q   <= owner_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         nc_data_q <= nc_data_d;
         db_data_q <= db_data_d;
      end
   end

   assign bus.init_done   = done_q;
   assign bus.wr_gnt      = wr_gnt_s;
   assign bus.nc_rd_gnt   = nc_gnt_s;
   assign bus.db_rd_gnt   = db_gnt_s;
   assign bus.nc_rd_valid = (owner_q == OWN_NC);
   assign bus.db_rd_valid = (owner_q == OWN_DB);
   assign bus.nc_rd_data  = nc_data_d;
   assign bus.db_rd_data  = db_data_d;
   assign bus.ram_cs      = cs_s;
   assign bus.ram_we      = we_s;
   assign bus.ram_addr    = addr_d;
   assign bus.ram_wdata   = wdata_d;

endmodule

// File: tb/tb_tc_ram_arbiter.sv
// Directed bench for tc_ram_arbiter with a behavioural single-port TC RAM.
module tb_tc_ram_arbiter;

   localparam int AW = 13;
   localparam int DW = 5;
   localparam int NWORDS = 8192;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   tc_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   tc_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: unwritten words read back as pat(addr); storage is XOR-coded
   bit [DW-1:0] mem [NWORDS];
   bit [DW-1:0] rdata_q;

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return a[4:0] ^ 5'h15;
   endfunction

   always @(posedge clk) begin
      if (bus.ram_cs) begin
         if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata ^ pat(bus.ram_addr);
         else            rdata_q <= mem[bus.ram_addr] ^ pat(bus.ram_addr);
      end
   end
   assign bus.ram_rdata = rdata_q;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.init_start = 1'b0;
      bus.wr_req     = 1'b0;
      bus.nc_rd_req  = 1'b0;
      bus.db_rd_req  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      bus.wr_addr = 13'h0000; bus.wr_data = 5'd0;
      bus.nc_rd_addr = 13'h0000; bus.db_rd_addr = 13'h0000;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.wr_gnt, bus.nc_rd_gnt, bus.db_rd_gnt} !== 3'b000) begin
         errors++; $display("FAIL reset_gnt: got %b expected 000", {bus.wr_gnt, bus.nc_rd_gnt, bus.db_rd_gnt});
      end
      checks++;
      if ({bus.nc_rd_valid, bus.db_rd_valid, bus.init_done} !== 3'b000) begin
         errors++; $display("FAIL reset_valid_done: got %b expected 000", {bus.nc_rd_valid, bus.db_rd_valid, bus.init_done});
      end
      checks++;
      if ({bus.ram_cs, bus.ram_we} !== 2'b00) begin
         errors++; $display("FAIL reset_ram_ctl: got %b expected 00", {bus.ram_cs, bus.ram_we});
      end
      checks++;
      if ({bus.nc_rd_data, bus.db_rd_data} !== 10'd0) begin
         errors++; $display("FAIL reset_rd_data: got %h expected 000", {bus.nc_rd_data, bus.db_rd_data});
      end
      @(negedge clk);
      reset = 1'b0;
      tick();
   endtask

   task automatic test_write_read();
      bus.wr_req = 1'b1; bus.wr_addr = 13'h0123; bus.wr_data = 5'd7;
      bus.nc_rd_req = 1'b1; bus.nc_rd_addr = 13'h0123;
      #1;
      checks++;
      if ({bus.wr_gnt, bus.nc_rd_gnt, bus.ram_cs, bus.ram_we} !== 4'b1011 || bus.ram_addr !== 13'h0123 || bus.ram_wdata !== 5'd7) begin
         errors++; $display("FAIL wr_first: got gnt/cs/we %b addr %h data %0d expected 1011 0123 7",
                            {bus.wr_gnt, bus.nc_rd_gnt, bus.ram_cs, bus.ram_we}, bus.ram_addr, bus.ram_wdata);
      end
      tick();
      bus.wr_req = 1'b0;
      #1;
      checks++;
      if ({bus.wr_gnt, bus.nc_rd_gnt, bus.ram_cs, bus.ram_we} !== 4'b0110 || bus.ram_addr !== 13'h0123) begin
         errors++; $display("FAIL nc_after_wr: got %b addr %h expected 0110 0123", {bus.wr_gnt, bus.nc_rd_gnt, bus.ram_cs, bus.ram_we}, bus.ram_addr);
      end
      tick();
      bus.nc_rd_req = 1'b0;
      #1;
      checks++;
      if (bus.nc_rd_valid !== 1'b1 || bus.nc_rd_data !== 5'd7 || bus.db_rd_valid !== 1'b0) begin
         errors++; $display("FAIL nc_return: got valid %b data %0d dbv %b expected 1 7 0", bus.nc_rd_valid, bus.nc_rd_data, bus.db_rd_valid);
      end
      checks++;
      if (bus.ram_cs !== 1'b0 || bus.ram_addr !== 13'h0123) begin
         errors++; $display("FAIL idle_hold: got cs %b addr %h expected 0 0123", bus.ram_cs, bus.ram_addr);
      end
      tick();
      checks++;
      if (bus.nc_rd_valid !== 1'b0 || bus.nc_rd_data !== 5'd7) begin
         errors++; $display("FAIL nc_data_hold: got valid %b data %0d expected 0 7", bus.nc_rd_valid, bus.nc_rd_data);
      end
   endtask

   task automatic test_contention();
      int bad;
      bad = 0;
      bus.nc_rd_req = 1'b1; bus.nc_rd_addr = 13'h0123;
      bus.db_rd_req = 1'b1; bus.db_rd_addr = 13'h0040;
      for (int c = 0; c < 7; c++) begin
         #1;
         checks++;
         if ({bus.nc_rd_gnt, bus.db_rd_gnt} !== ((c == 4) ? 2'b01 : 2'b10)) begin
            errors++; $display("FAIL contention_c%0d: got nc/db %b expected %b", c, {bus.nc_rd_gnt, bus.db_rd_gnt}, (c == 4) ? 2'b01 : 2'b10);
         end
         if (c == 5) begin
            checks++;
            if (bus.db_rd_valid !== 1'b1 || bus.db_rd_data !== 5'd21 || bus.nc_rd_valid !== 1'b0) begin
               errors++; $display("FAIL db_return: got valid %b data %0d expected 1 21", bus.db_rd_valid, bus.db_rd_data);
            end
         end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_starve_vs_write();
      int bad;
      bad = 0;
      bus.nc_rd_req = 1'b1; bus.nc_rd_addr = 13'h0123;
      bus.db_rd_req = 1'b1; bus.db_rd_addr = 13'h0041;
      for (int c = 0; c < 4; c++) begin
         #1;
         if ({bus.nc_rd_gnt, bus.db_rd_gnt} !== 2'b10) bad++;
         tick();
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL starve_build: got %0d bad cycles expected 0", bad);
      end
      bus.wr_req = 1'b1; bus.wr_addr = 13'h0200; bus.wr_data = 5'd3;
      #1;
      checks++;
      if ({bus.wr_gnt, bus.nc_rd_gnt, bus.db_rd_gnt} !== 3'b100) begin
         errors++; $display("FAIL wr_over_starved: got %b expected 100", {bus.wr_gnt, bus.nc_rd_gnt, bus.db_rd_gnt});
      end
      tick();
      bus.wr_req = 1'b0;
      #1;
      checks++;
      if ({bus.wr_gnt, bus.nc_rd_gnt, bus.db_rd_gnt} !== 3'b001) begin
         errors++; $display("FAIL starved_db_next: got %b expected 001", {bus.wr_gnt, bus.nc_rd_gnt, bus.db_rd_gnt});
      end
      tick();
      bus.db_rd_req = 1'b0;
      #1;
      checks++;
      if (bus.db_rd_valid !== 1'b1 || bus.db_rd_data !== 5'd20 || bus.nc_rd_gnt !== 1'b1) begin
         errors++; $display("FAIL starve_return: got valid %b data %0d ncg %b expected 1 20 1", bus.db_rd_valid, bus.db_rd_data, bus.nc_rd_gnt);
      end
      idle_inputs();
      tick();
      tick();
   endtask

   task automatic test_clear();
      int bad;
      bad = 0;
      bus.init_start = 1'b1;
      #1;
      checks++;
      if (bus.ram_cs !== 1'b0 || bus.init_done !== 1'b0) begin
         errors++; $display("FAIL clear_start: got cs %b done %b expected 0 0", bus.ram_cs, bus.init_done);
      end
      tick();
      bus.init_start = 1'b0;
      bus.nc_rd_req = 1'b1; bus.nc_rd_addr = 13'h0123;
      for (int i = 0; i < NWORDS; i++) begin
         #1;
         if (bus.ram_cs !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_wdata !== 5'd0 || bus.ram_addr !== 13'(i) ||
             {bus.wr_gnt, bus.nc_rd_gnt, bus.db_rd_gnt, bus.init_done} !== 4'b0000) begin
            if (bad < 4) $display("FAIL clear_sweep_%0d: got cs %b we %b addr %h data %0d gnt/done %b expected 1 1 %h 0 0000",
                                  i, bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_wdata,
                                  {bus.wr_gnt, bus.nc_rd_gnt, bus.db_rd_gnt, bus.init_done}, 13'(i));
            bad++;
         end
         tick();
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL clear_sweep: got %0d bad cycles expected 0", bad);
      end
      #1;
      checks++;
      if (bus.init_done !== 1'b1 || bus.nc_rd_gnt !== 1'b1 || bus.ram_we !== 1'b0) begin
         errors++; $display("FAIL clear_done: got done %b ncg %b we %b expected 1 1 0", bus.init_done, bus.nc_rd_gnt, bus.ram_we);
      end
      tick();
      bus.nc_rd_req = 1'b0;
      bus.db_rd_req = 1'b1; bus.db_rd_addr = 13'h0200;
      #1;
      checks++;
      if (bus.init_done !== 1'b0 || bus.nc_rd_valid !== 1'b1 || bus.nc_rd_data !== 5'd0 || bus.db_rd_gnt !== 1'b1) begin
         errors++; $display("FAIL clear_read_nc: got done %b valid %b data %0d dbg %b expected 0 1 0 1",
                            bus.init_done, bus.nc_rd_valid, bus.nc_rd_data, bus.db_rd_gnt);
      end
      tick();
      bus.db_rd_req = 1'b0;
      #1;
      checks++;
      if (bus.db_rd_valid !== 1'b1 || bus.db_rd_data !== 5'd0) begin
         errors++; $display("FAIL clear_read_db: got valid %b data %0d expected 1 0", bus.db_rd_valid, bus.db_rd_data);
      end
      tick();
   endtask

   task automatic test_restart_abort();
      int bad;
      bad = 0;
      bus.init_start = 1'b1;
      tick();
      bus.init_start = 1'b0;
      repeat (9) tick();
      bus.init_start = 1'b1;
      #1;
      checks++;
      if (bus.ram_addr !== 13'd9) begin
         errors++; $display("FAIL restart_at9: got addr %h expected 0009", bus.ram_addr);
      end
      tick();
      bus.init_start = 1'b0;
      for (int i = 0; i < NWORDS; i++) begin
         #1;
         if (bus.ram_addr !== 13'(i) || bus.init_done !== 1'b0 || bus.ram_we !== 1'b1) bad++;
         tick();
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL restart_sweep: got %0d bad cycles expected 0", bad);
      end
      #1;
      checks++;
      if (bus.init_done !== 1'b1) begin
         errors++; $display("FAIL restart_done: got %b expected 1", bus.init_done);
      end
      tick();
      bus.init_start = 1'b1;
      tick();
      bus.init_start = 1'b0;
      repeat (5) tick();
      checks++;
      if (bus.ram_addr !== 13'd5 || bus.ram_we !== 1'b1) begin
         errors++; $display("FAIL abort_at5: got addr %h we %b expected 0005 1", bus.ram_addr, bus.ram_we);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (bus.ram_cs !== 1'b0 || bus.ram_we !== 1'b0 || bus.init_done !== 1'b0) begin
         errors++; $display("FAIL abort_reset: got cs %b we %b done %b expected 0 0 0", bus.ram_cs, bus.ram_we, bus.init_done);
      end
      @(negedge clk);
      reset = 1'b0;
      tick();
      bus.wr_req = 1'b1; bus.wr_addr = 13'h0300; bus.wr_data = 5'd5;
      #1;
      checks++;
      if (bus.wr_gnt !== 1'b1 || bus.ram_addr !== 13'h0300) begin
         errors++; $display("FAIL abort_serve: got wrg %b addr %h expected 1 0300", bus.wr_gnt, bus.ram_addr);
      end
      tick();
      bus.wr_req = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.init_done !== 1'b0) bad++;
         tick();
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL abort_no_done: got %0d done cycles expected 0", bad);
      end
   endtask

   task automatic test_inflight();
      bus.wr_req = 1'b1; bus.wr_addr = 13'h0055; bus.wr_data = 5'd9;
      tick();
      bus.wr_req = 1'b0;
      bus.init_start = 1'b1;
      bus.db_rd_req = 1'b1; bus.db_rd_addr = 13'h0055;
      #1;
      checks++;
      if (bus.db_rd_gnt !== 1'b1 || bus.ram_we !== 1'b0) begin
         errors++; $display("FAIL inflight_gnt: got dbg %b we %b expected 1 0", bus.db_rd_gnt, bus.ram_we);
      end
      tick();
      bus.init_start = 1'b0;
      bus.db_rd_req = 1'b0;
      #1;
      checks++;
      if (bus.db_rd_valid !== 1'b1 || bus.db_rd_data !== 5'd9 || bus.ram_we !== 1'b1 || bus.ram_addr !== 13'd0 ||
          {bus.wr_gnt, bus.nc_rd_gnt, bus.db_rd_gnt} !== 3'b000) begin
         errors++; $display("FAIL inflight_return: got valid %b data %0d we %b addr %h gnt %b expected 1 9 1 0000 000",
                            bus.db_rd_valid, bus.db_rd_data, bus.ram_we, bus.ram_addr, {bus.wr_gnt, bus.nc_rd_gnt, bus.db_rd_gnt});
      end
      for (int i = 0; i < NWORDS; i++) tick();
      checks++;
      if (bus.init_done !== 1'b1 || bus.db_rd_valid !== 1'b0) begin
         errors++; $display("FAIL inflight_done: got done %b valid %b expected 1 0", bus.init_done, bus.db_rd_valid);
      end
      tick();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_write_read();
      test_contention();
      test_starve_vs_write();
      test_clear();
      test_restart_abort();
      test_inflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tc_ram_arbiter.md
Name: tc_ram_arbiter

Overview:
- Owns the single-port TotalCoeff (TC) RAM and shares it between three requesters.
- Requester 1: the CAVLC TotalCoeff write-back.
- Requester 2: the nC neighbour read (nA/nB lookups).
- Requester 3: the deblocking-filter bS read.
- Also sequences a picture-start clear that zeroes the whole RAM. Sits between the CAVLC/deblock blocks and the TC RAM macro.

Parameters:
ADDR_W, 13, TC RAM address width ({mb_h[6:0], mb_v[0], blk[4:0]})
DATA_W, 5, TotalCoeff width
STARVE_MAX, 4, consecutive lost cycles after which the deblock read is promoted above the nC read

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
init_start  in  1  pulse: begin RAM clear
init_done  out  1  one-cycle pulse when clear completes
wr_req  in  1  TotalCoeff write request; held until granted
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  TotalCoeff value
wr_gnt  out  1  write accepted this cycle
nc_rd_req  in  1  nC read request; held until granted
nc_rd_addr  in  ADDR_W  nC read address
nc_rd_gnt  out  1  nC read accepted this cycle
nc_rd_valid  out  1  nc_rd_data valid
nc_rd_data  out  DATA_W  read data
db_rd_req  in  1  deblock read request
db_rd_addr  in  ADDR_W  deblock read address
db_rd_gnt  out  1  deblock read accepted
db_rd_valid  out  1  db_rd_data valid
db_rd_data  out  DATA_W  read data
ram_cs  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid the cycle after a read access

Behaviour:
- Clock is clk. Reset is asynchronous and active-high on port reset. No other clock or reset.
- Reset values:
  - State SERVE; clear counter 0; starve_cnt 0; owner tag NONE.
  - All gnt, valid, ram_cs, ram_we and init_done are 0.
  - nc_rd_data and db_rd_data are 0.
- FSM has two states: SERVE and CLEAR.
- SERVE:
  - Init_start=1 moves to CLEAR next cycle, counter=0. Requests in that same cycle are still arbitrated normally.
  - Arbitration is combinational within the cycle.
  - Priority order: wr first; then db if starve_cnt==STARVE_MAX; then nc; then db.
  - Exactly one gnt is asserted per cycle, or none if no request.
  - The granted request drives the RAM port in the same cycle: ram_cs=1, ram_we=1 only for wr, ram_addr/ram_wdata from the winner.
  - No request: ram_cs=0, ram_we=0, ram_addr/ram_wdata hold their last value.
- CLEAR:
  - All gnt=0. Each cycle: ram_cs=1, ram_we=1, ram_addr=counter, ram_wdata=0, then counter+1.
  - After writing address 2^ADDR_W-1: go to SERVE, counter wraps to 0, init_done=1 for one cycle on the first SERVE cycle.
  - Init_start during CLEAR restarts counter at 0 and extends the clear. No init_done until the full sweep finishes.
- Read return:
  - An owner tag (NONE/NC/DB) is registered at a read grant.
  - In the next cycle the matching *_rd_valid=1 and *_rd_data=ram_rdata. Read latency is 1 cycle after grant.
  - The non-owner's valid stays 0. Rd_data registers hold the last returned value.
  - A read granted in the last SERVE cycle before CLEAR still returns its valid in the first CLEAR cycle.
- Starvation counter:
  - Increments each cycle db_rd_req=1 and db_rd_gnt=0, saturating at STARVE_MAX.
  - Cleared to 0 on db_rd_gnt or when db_rd_req=0.
  - Write always wins, even over a starved db.
- Ordering: a write granted in cycle N followed by a read of the same address granted in N+1 or later returns the new value. A read never bypasses a pending write, because the write has top priority.
- Requesters must hold req and addr stable until gnt. Behaviour is undefined if they drop it early.
- Reset asserted mid-CLEAR or mid-read: immediate return to reset values. No init_done and no valid for the aborted operation.

Decomposition:
- Shared package (e.g. tc_ram_pkg) holds:
  - owner-tag encoding: NONE=2'd0, NC=2'd1, DB=2'd2;
  - FSM encoding: SERVE, CLEAR;
  - TC address field widths, shared with nC decode and deblock.
- One natural sub-module: tc_arb_prio — combinational fixed-priority grant with starvation promotion. The FSM, counter and return pipeline stay in the top module.

Test Plan:
- Write-then-read: wr_req addr 0x0123 data 7 at cycle 0, then nc_rd_req addr 0x0123 at cycle 0 -> cycle 0 wr_gnt=1 and ram_we=1; cycle 1 nc_rd_gnt=1; cycle 2 nc_rd_valid=1, nc_rd_data=7.
- Contention: nc_rd_req and db_rd_req continuously high, STARVE_MAX=4 -> nc wins cycles 0-3, db_rd_gnt at cycle 4, starve_cnt returns to 0, nc wins again from cycle 5.
- Starved db vs write: starve_cnt=4 and wr_req=1 in the same cycle -> wr_gnt=1, db waits, db_rd_gnt=1 on the next cycle when wr_req=0.
- Clear with ADDR_W=4: init_start pulse -> 16 cycles of ram_we=1, ram_wdata=0, addresses 0..15; all gnt=0; init_done=1 on the next cycle; a read of any address then returns 0.
- Restart and abort: init_start re-pulsed at counter=9 -> counter restarts at 0 and init_done comes 16 cycles later. Reset asserted at counter=5 -> ram_cs=0 and state SERVE immediately, no init_done.
- In-flight read: db read granted in the cycle init_start is sampled -> db_rd_valid=1 with the RAM data in the first CLEAR cycle; no gnt during CLEAR.
